// File: rtl/legv8_pkg.sv
// legv8_pkg: shared state encoding, widths and the writeback bundle for the LEGv8 memory stage
package legv8_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 64;
    typedef enum logic {IDLE, ACCESS} state_e;
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
    } wb_t;
endpackage

// File: rtl/dm_handshake.sv
// dm_handshake: req/ack data-memory FSM holding the request until acknowledged
module dm_handshake
    import legv8_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic         misaligned,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    input  logic         dm_ack,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    output logic         stall,
    output logic         done
);
    state_e       state_q, state_d;
    logic         req_q, req_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic         start;

    always_comb begin
        start   = accept & (mem_read | mem_write) & ~misaligned;
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done    = (state_q == ACCESS) & dm_ack;
        if (state_q == IDLE && start) begin
            state_d = ACCESS;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = addr;
            wdata_d = wdata;
        end else if (done) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign stall    = (state_q == ACCESS);
    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
endmodule

// File: rtl/memory_access.sv
// memory_access: LEGv8 memory stage with req/ack data bus; optional MISALIGN_CHECK_EN adds misaligned_M
module memory_access
    import legv8_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_E,
    input  logic             MemRead_E,
    input  logic             MemWrite_E,
    input  logic             Branch_E,
    input  logic             RegWrite_E,
    input  logic             MemtoReg_E,
    input  logic [REG_W-1:0] rd_E,
    input  logic [N-1:0]     aluResult_E,
    input  logic [N-1:0]     writeData_E,
    input  logic [N-1:0]     PCBranch_E,
    input  logic             zero_E,
    output logic             stall_M,
    output logic             PCSrc_M,
    output logic [N-1:0]     PCBranch_M,
    output logic             dm_req,
    output logic             dm_we,
    output logic [N-1:0]     dm_addr,
    output logic [N-1:0]     dm_wdata,
    input  logic             dm_ack,
    input  logic [N-1:0]     dm_rdata,
`ifdef MISALIGN_CHECK_EN
    output logic             misaligned_M,
`endif
    output logic             valid_W,
    output logic             RegWrite_W,
    output logic             MemtoReg_W,
    output logic [REG_W-1:0] rd_W,
    output logic [N-1:0]     aluResult_W,
    output logic [N-1:0]     readData_W
);
    logic         accept, mem_op, mis, done;
    wb_t          hold_q, hold_d, wb_q, wb_d;
    logic         valid_q, valid_d;
    logic         pcsrc_q, pcsrc_d;
    logic [N-1:0] pcbranch_q, pcbranch_d;

    assign accept = valid_E & ~stall_M;
    assign mem_op = MemRead_E | MemWrite_E;

`ifdef MISALIGN_CHECK_EN
    logic mis_q;
    assign mis = accept & mem_op & (|aluResult_E[2:0]);
    always_ff @(posedge clk) mis_q <= reset ? 1'b0 : mis;
    assign misaligned_M = mis_q;
`else
    assign mis = 1'b0;
`endif

    dm_handshake #(.N(N)) u_hs (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .mem_read  (MemRead_E),
        .mem_write (MemWrite_E),
        .misaligned(mis),
        .addr      (aluResult_E),
        .wdata     (writeData_E),
        .dm_ack    (dm_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .stall     (stall_M),
        .done      (done)
    );

    always_comb begin
        hold_d     = hold_q;
        wb_d       = wb_q;
        valid_d    = 1'b0;
        pcsrc_d    = accept & Branch_E & zero_E;
        pcbranch_d = accept ? PCBranch_E : pcbranch_q;
        if (accept && mem_op && !mis) begin
            // a write paired with a read wins, so the register write is suppressed
            hold_d = '{reg_write: RegWrite_E & ~(MemRead_E & MemWrite_E), mem_to_reg: MemtoReg_E,
                       rd: rd_E, alu_result: aluResult_E, read_data: '0};
        end else if (accept) begin
            valid_d = 1'b1;
            wb_d    = '{reg_write: RegWrite_E & ~mis, mem_to_reg: MemtoReg_E,
                        rd: rd_E, alu_result: aluResult_E, read_data: '0};
        end else if (done) begin
            valid_d        = 1'b1;
            wb_d           = hold_q;
            wb_d.read_data = dm_we ? '0 : dm_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            wb_q       <= '0;
            valid_q    <= 1'b0;
            pcsrc_q    <= 1'b0;
            pcbranch_q <= '0;
        end else begin
            hold_q     <= hold_d;
            wb_q       <= wb_d;
            valid_q    <= valid_d;
            pcsrc_q    <= pcsrc_d;
            pcbranch_q <= pcbranch_d;
        end
    end

    assign valid_W     = valid_q;
    assign RegWrite_W  = valid_q & wb_q.reg_write;
    assign MemtoReg_W  = wb_q.mem_to_reg;
    assign rd_W        = wb_q.rd;
    assign aluResult_W = wb_q.alu_result;
    assign readData_W  = wb_q.read_data;
    assign PCSrc_M     = pcsrc_q;
    assign PCBranch_M  = pcbranch_q;
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the pipelined LEGv8 datapath.
- Consumes the execute-stage results: ALU result as address, store data, branch target and zero flag.
- Drives a req/ack data-memory bus for LDUR/STUR and stalls upstream while an access is outstanding.
- Resolves CBZ/B branch selection and presents registered results to writeback.

Parameters:
N, 64, datapath width (address, data, PC)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
valid_E  in  1  execute stage holds a valid instruction
MemRead_E  in  1  load
MemWrite_E  in  1  store
Branch_E  in  1  conditional/unconditional branch
RegWrite_E  in  1  writeback enable
MemtoReg_E  in  1  writeback selects memory data
rd_E  in  5  destination register
aluResult_E  in  N  ALU result / memory address
writeData_E  in  N  store data
PCBranch_E  in  N  branch target
zero_E  in  1  ALU zero flag
stall_M  out  1  upstream must hold execute stage
PCSrc_M  out  1  take branch (one-cycle pulse)
PCBranch_M  out  N  registered branch target
dm_req  out  1  memory request
dm_we  out  1  1 = write
dm_addr  out  N  byte address
dm_wdata  out  N  write data
dm_ack  in  1  memory completed request
dm_rdata  in  N  read data, valid with dm_ack
valid_W  out  1  writeback entry valid (one cycle per instruction)
RegWrite_W  out  1  qualified by valid_W
MemtoReg_W  out  1
rd_W  out  5
aluResult_W  out  N
readData_W  out  N

Behaviour:
- Clock/reset: clk and reset only; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE.
- States:
  - IDLE: accepts an instruction every cycle. Accept = valid_E & ~stall_M, sampled at the rising edge.
  - ACCESS: a memory request is outstanding.
- stall_M = (state == ACCESS), combinational from state only. Every memory op therefore costs at least one bubble.
- Non-memory op accepted (neither MemRead_E nor MemWrite_E):
  - W registers load from the _E inputs; valid_W = 1 the next cycle.
  - readData_W = 0.
  - Latency 1.
- Memory op accepted:
  - Request registers load: dm_addr = aluResult_E, dm_wdata = writeData_E, dm_we = MemWrite_E.
  - Writeback fields go to M-holding registers.
  - State -> ACCESS; dm_req = 1 from the next cycle.
- ACCESS:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable until dm_ack is sampled high.
  - On the ack edge: readData_W <= dm_rdata (load) or 0 (store); W loads the held fields; valid_W = 1 next cycle; dm_req = 0 next cycle; state -> IDLE.
  - Minimum memory-op latency is 2 cycles (ack in the first request cycle).
- Simultaneous MemRead_E & MemWrite_E: the write wins, dm_we = 1, and RegWrite_W is forced to 0.
- Branch:
  - At an accept edge: PCSrc_M <= Branch_E & zero_E and PCBranch_M <= PCBranch_E.
  - Otherwise PCSrc_M <= 0, so the output is a single-cycle pulse.
  - Flushing is owned by the hazard unit, not this block.
- valid_W is a single-cycle pulse per completed instruction; it is 0 during ACCESS and on idle cycles.
- dm_ack is ignored while in IDLE.
- Reset mid-ACCESS: next cycle state = IDLE and dm_req = 0. A late ack is ignored; the memory model must tolerate abandoned requests.
- Address arithmetic: no modification; the byte address is passed as is.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned_M (1 bit, reset 0).
  - If an accepted memory op has aluResult_E[2:0] != 0: no dm_req is issued and the state stays IDLE.
  - misaligned_M pulses for one cycle; valid_W pulses with RegWrite_W = 0.
- Undefined:
  - No port and no check; misaligned addresses are issued unchanged.

Decomposition:
- legv8_pkg holds:
  - state enum {IDLE, ACCESS};
  - localparam REG_W = 5;
  - a packed struct for the writeback bundle (RegWrite, MemtoReg, rd, aluResult, readData).
- One sub-module, dm_handshake, contains the FSM plus the request-holding registers. It drives dm_*, stall_M and the completion strobe.
- The top level holds the W and branch registers.

Test Plan:
- Non-memory op:
  - Stimulus: ADD with aluResult_E=0x10, rd_E=3, RegWrite_E=1.
  - Response: the next cycle gives valid_W=1, aluResult_W=0x10, rd_W=3, readData_W=0; stall_M stays 0.
- Load with 3-cycle ack delay:
  - Stimulus: LDUR with addr 0x40; memory returns dm_rdata=0xDEADBEEF.
  - Response: dm_req held with addr 0x40 and dm_we=0 until ack; stall_M=1 for 3 cycles; then valid_W=1, readData_W=0xDEADBEEF, MemtoReg_W=1.
- Store with immediate ack:
  - Stimulus: STUR with addr 0x08, writeData_E=0x55, ack in the first request cycle.
  - Response: dm_we=1, dm_wdata=0x55; total latency 2; valid_W pulse with readData_W=0.
- Branch:
  - Stimulus: CBZ with zero_E=1, PCBranch_E=0x100.
  - Response: PCSrc_M=1 for exactly one cycle, PCBranch_M=0x100.
  - Repeat with zero_E=0: PCSrc_M stays 0.
- Reset mid-access:
  - Stimulus: reset during ACCESS, with dm_ack asserted one cycle after reset.
  - Response: dm_req=0 and stall_M=0 the next cycle; no valid_W; the late ack is ignored.
- Misaligned access (MISALIGN_CHECK_EN defined):
  - Stimulus: load at address 0x43.
  - Response: no dm_req; misaligned_M pulse; valid_W pulse with RegWrite_W=0.
